uart_bcd_ctrl: RTL and testbench

Board-level UART node for a 50 MHz FPGA.
- A debounced push button (SendItem) transmits one 8N1 byte taken from the slide switches on DataOut.
- Bytes received on DataIn are stored.
- Three active-low 7-segment digits show the decimal value (000–255) of either the last received byte or the switch byte.

---
 rtl/uart_bcd_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_uart_bcd_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/uart_bcd_ctrl.sv
// UART node: debounced button sends the switch byte as 8N1 on DataOut, received bytes
// are stored, and three active-low 7-segment digits show either byte in decimal.
module uart_bcd_ctrl #(
  parameter int CLK_FREQ        = 50000000,
  parameter int BAUD            = 9600,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic        src_clk,
  input  logic        rst,
  input  logic [9:0]  Switches,
  input  logic        DataIn,
  input  logic        SendItem,
  output logic        DataOut,
  output logic [20:0] Display_out
);

  localparam int CPB  = CLK_FREQ / BAUD;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB + 1);
  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'b1000000;
      4'd1: seg7 = 7'b1111001;
      4'd2: seg7 = 7'b0100100;
      4'd3: seg7 = 7'b0110000;
      4'd4: seg7 = 7'b0011001;
      4'd5: seg7 = 7'b0010010;
      4'd6: seg7 = 7'b0000010;
      4'd7: seg7 = 7'b1111000;
      4'd8: seg7 = 7'b0000000;
      4'd9: seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  logic          rx_s1_q, rx_s2_q, rx_prev_q, btn_s1_q, btn_s2_q;
  logic          btn_db_q, btn_db_d, btn_prev_q;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  state_t        tx_state_q, tx_state_d, rx_state_q, rx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [2:0]    tx_idx_q, tx_idx_d, rx_idx_q, rx_idx_d;
  logic [7:0]    tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          tx_out_q, tx_out_d;
  logic [20:0]   disp_q, disp_d;
  logic          send_trig;
  logic [7:0]    value;

  // The counter only runs while the synced button disagrees with the debounced state.
  always_comb begin
    btn_db_d = btn_db_q;
    db_cnt_d = '0;
    if (btn_s2_q != btn_db_q) begin
      if (db_cnt_q == DW'(DEBOUNCE_CYCLES - 1)) btn_db_d = btn_s2_q;
      else db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  assign send_trig = btn_db_q & ~btn_prev_q & Switches[0] & (tx_state_q == S_IDLE);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 1'b1;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    tx_out_d   = tx_out_q;
    case (tx_state_q)
      S_IDLE: begin
        tx_cnt_d = '0;
        tx_out_d = 1'b1;
        if (send_trig) begin
          tx_state_d = S_START;
          tx_shift_d = Switches[9:2];
          tx_out_d   = 1'b0;
        end
      end
      S_START: if (tx_cnt_q == CW'(CPB - 1)) begin
        tx_cnt_d   = '0;
        tx_idx_d   = '0;
        tx_state_d = S_DATA;
        tx_out_d   = tx_shift_q[0];
        tx_shift_d = {1'b0, tx_shift_q[7:1]};
      end
      S_DATA: if (tx_cnt_q == CW'(CPB - 1)) begin
        tx_cnt_d = '0;
        if (tx_idx_q == 3'd7) begin
          tx_state_d = S_STOP;
          tx_out_d   = 1'b1;
        end else begin
          tx_idx_d   = tx_idx_q + 1'b1;
          tx_out_d   = tx_shift_q[0];
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
        end
      end
      default: if (tx_cnt_q == CW'(CPB - 1)) begin
        tx_cnt_d   = '0;
        tx_state_d = S_IDLE;
      end
    endcase
  end

  // RX arms only on a high-to-low transition, so a line stuck low cannot retrigger.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 1'b1;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    rx_byte_d  = rx_byte_q;
    case (rx_state_q)
      S_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_s2_q) rx_state_d = S_START;
      end
      S_START: if (rx_cnt_q == CW'(HALF - 1)) begin
        rx_cnt_d   = '0;
        rx_idx_d   = '0;
        rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
      end
      S_DATA: if (rx_cnt_q == CW'(CPB - 1)) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
        if (rx_idx_q == 3'd7) rx_state_d = S_STOP;
        else rx_idx_d = rx_idx_q + 1'b1;
      end
      default: if (rx_cnt_q == CW'(CPB - 1)) begin
        rx_cnt_d   = '0;
        rx_state_d = S_IDLE;
        if (rx_s2_q) rx_byte_d = rx_shift_q;
      end
    endcase
  end

  always_comb begin
    value  = Switches[1] ? Switches[9:2] : rx_byte_q;
    disp_d = {seg7(4'(value / 8'd100)), seg7(4'((value / 8'd10) % 8'd10)), seg7(4'(value % 8'd10))};
  end

  always_ff @(posedge src_clk or posedge rst) begin
    if (rst) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      btn_s1_q   <= 1'b0;
      btn_s2_q   <= 1'b0;
      btn_db_q   <= 1'b0;
      btn_prev_q <= 1'b0;
      db_cnt_q   <= '0;
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      tx_out_q   <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rx_byte_q  <= '0;
      disp_q     <= {3{7'b1000000}};
    end else begin
      rx_s1_q    <= DataIn;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      btn_s1_q   <= SendItem;
      btn_s2_q   <= btn_s1_q;
      btn_db_q   <= btn_db_d;
      btn_prev_q <= btn_db_q;
      db_cnt_q   <= db_cnt_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      tx_out_q   <= tx_out_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      rx_byte_q  <= rx_byte_d;
      disp_q     <= disp_d;
    end
  end

  assign DataOut     = tx_out_q;
  assign Display_out = disp_q;

endmodule

// File: tb/tb_uart_bcd_ctrl.sv
// Directed bench for uart_bcd_ctrl with shortened bit time (16 clocks) and debounce (20 clocks).
module tb_uart_bcd_ctrl;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
  localparam logic [20:0] D000 = {7'b1000000, 7'b1000000, 7'b1000000};
  localparam logic [20:0] D181 = {7'b1111001, 7'b0000000, 7'b1111001};
  localparam logic [20:0] D255 = {7'b0100100, 7'b0010010, 7'b0010010};
  localparam logic [20:0] D090 = {7'b1000000, 7'b0010000, 7'b1000000};
  localparam logic [20:0] D123 = {7'b1111001, 7'b0100100, 7'b0110000};

  logic        src_clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  sw = '0;
  logic        din_drv = 1'b1;
  logic        loop_en = 1'b0;
  logic        send_item = 1'b0;
  logic        data_in;
  logic        data_out;
  logic [20:0] disp;
  int          n_cmp = 0;
  int          n_err = 0;
  int          low_cnt = 0;
  int          l0;
  bit          ok;

  assign data_in = loop_en ? data_out : din_drv;

  always #5 src_clk = ~src_clk;

  always @(negedge src_clk) if (data_out === 1'b0) low_cnt++;

  uart_bcd_ctrl #(.CLK_FREQ(1600), .BAUD(100), .DEBOUNCE_CYCLES(20)) dut (
    .src_clk(src_clk), .rst(rst), .Switches(sw), .DataIn(data_in),
    .SendItem(send_item), .DataOut(data_out), .Display_out(disp)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge src_clk);
  endtask

  task automatic wait_fall(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge src_clk);
      if (data_out === 1'b0) begin
        seen = 1'b1;
        break;
      end
    end
    chk("tx_start_seen", 32'(seen), 32'd1);
  endtask

  // Samples the ten bit centres of a frame, start bit first.
  task automatic tx_check(input string tag, input logic [7:0] b);
    bit seen;
    logic [9:0] f;
    wait_fall(seen);
    if (seen) begin
      cycles(HALF - 1);
      f[0] = data_out;
      for (int k = 1; k < 10; k++) begin
        cycles(CPB);
        f[k] = data_out;
      end
      chk(tag, 32'(f), 32'({1'b1, b, 1'b0}));
    end
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stop_bit);
    @(negedge src_clk);
    din_drv = 1'b0;
    cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      din_drv = b[i];
      cycles(CPB);
    end
    din_drv = stop_bit;
    cycles(CPB);
    din_drv = 1'b1;
  endtask

  initial begin
    cycles(3);
    chk("reset_dataout", 32'(data_out), 32'd1);
    chk("reset_display", 32'(disp), 32'(D000));
    rst = 1'b0;
    cycles(5);
    chk("post_reset_display", 32'(disp), 32'(D000));

    sw = {8'hB5, 2'b10};
    cycles(2);
    chk("disp_sw_181", 32'(disp), 32'(D181));
    sw = {8'hFF, 2'b10};
    cycles(2);
    chk("disp_sw_255", 32'(disp), 32'(D255));

    sw = {8'hB5, 2'b11};
    l0 = low_cnt;
    send_item = 1'b1; cycles(10);
    send_item = 1'b0; cycles(10);
    send_item = 1'b1; cycles(10);
    send_item = 1'b0; cycles(60);
    chk("bounce_no_frame", 32'(low_cnt - l0), 32'd0);

    send_item = 1'b1;
    tx_check("tx_frame_b5", 8'hB5);
    l0 = low_cnt;
    cycles(300);
    chk("hold_single_frame", 32'(low_cnt - l0), 32'd0);
    send_item = 1'b0;
    cycles(40);

    sw = {8'hB5, 2'b10};
    l0 = low_cnt;
    send_item = 1'b1; cycles(80);
    send_item = 1'b0; cycles(40);
    chk("tx_disabled", 32'(low_cnt - l0), 32'd0);

    sw = {8'h00, 2'b00};
    cycles(2);
    chk("disp_rx_initial", 32'(disp), 32'(D000));
    rx_send(8'h5A, 1'b1);
    cycles(10);
    chk("rx_5a_090", 32'(disp), 32'(D090));
    rx_send(8'h33, 1'b0);
    cycles(30);
    chk("rx_framing_err", 32'(disp), 32'(D090));

    @(negedge src_clk);
    din_drv = 1'b0; cycles(3);
    din_drv = 1'b1; cycles(200);
    chk("rx_glitch", 32'(disp), 32'(D090));

    loop_en = 1'b1;
    sw = {8'h7B, 2'b01};
    send_item = 1'b1;
    cycles(10 * CPB + 60);
    send_item = 1'b0;
    cycles(40);
    chk("loopback_123", 32'(disp), 32'(D123));
    loop_en = 1'b0;

    sw = {8'hB5, 2'b01};
    send_item = 1'b1;
    wait_fall(ok);
    cycles(4);
    chk("mid_frame_low", 32'(data_out), 32'd0);
    #2 rst = 1'b1;
    #1 chk("rst_async_dataout", 32'(data_out), 32'd1);
    chk("rst_display", 32'(disp), 32'(D000));
    send_item = 1'b0;
    cycles(5);
    rst = 1'b0;
    l0 = low_cnt;
    cycles(40);
    chk("post_rst_idle", 32'(low_cnt - l0), 32'd0);
    send_item = 1'b1;
    tx_check("tx_after_reset", 8'hB5);
    send_item = 1'b0;
    cycles(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
